cla_16_bit_ripple: RTL and testbench
====================================

CLA_16_BIT_RIPPLE -- requirements
Module: cla_16_bit_ripple

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  16  unsigned operand A.
REQ-005 b  input  16  unsigned operand B.
REQ-006 c_in  input  1  carry into bit 0.
REQ-007 sum  output  16  registered sum bits [15:0].
REQ-008 c_out  output  1  registered carry out of bit 15.
REQ-009 The block SHALL use one clock, with an asynchronous, active-low reset.

Function
REQ-010 The block SHALL compute {c_out, sum} = a + b + c_in as a 17-bit unsigned result, with no overflow flag and no saturation.
REQ-011 The datapath SHALL consist of four 4-bit carry-lookahead slices: slice k covers bits [4k+3:4k].
REQ-012 Each slice SHALL form per-bit generate g = a&b and propagate p = a^b.
REQ-013 Each slice SHALL derive its carries c1..c4 from g, p and the slice carry-in using two-level lookahead equations, not a bit-serial chain.
REQ-014 Each slice sum bit SHALL equal p XOR the carry into that bit.
REQ-015 Slice carry-out c4 SHALL ripple into the next slice's carry-in: slice 0 takes c_in, and slice 3's c4 is the result carry.
REQ-016 The combinational result SHALL be captured into the sum/c_out registers on every rising clk edge, with no enable.
REQ-017 Latency SHALL be 1 cycle: inputs sampled at edge N appear on the outputs after edge N and hold until edge N+1.
REQ-018 The outputs SHALL depend only on the sampled a, b and c_in, with no internal history or accumulation.
REQ-019 Boundary: a = b = 16'h8000 with c_in=0 SHALL give sum=0 and c_out=1.
REQ-020 Boundary: a=16'hFFFF, b=0, c_in=1 SHALL give sum=0 and c_out=1, with the carry propagating through all four slices within one cycle.
REQ-021 Boundary: a=b=16'hFFFF with c_in=1 SHALL give sum=16'hFFFF and c_out=1.
REQ-022 The combinational path from a/b/c_in to the register D inputs SHALL settle within one clock period at the target frequency; there is no multicycle path.

Reset
REQ-023 While rst_n=0, sum SHALL be 16'h0000 and c_out SHALL be 0, immediately and independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard the in-flight result; outputs stay at zero while rst_n=0.
REQ-025 After rst_n deasserts, the first rising clk edge SHALL load a+b+c_in normally.
REQ-026 The reset release SHALL be synchronized externally; the block requires no extra recovery cycles.

Verification
REQ-027 Scenario: rst_n=0 with arbitrary inputs and clock running -> sum=0 and c_out=0; on release, the next edge loads the live result.
REQ-028 Scenario: a=12345, b=32914 (98450 truncated to 16 bits), c_in=0 -> one cycle later sum=45259 and c_out=0.
REQ-029 Scenario: a=32768, b=32768, c_in=0 -> sum=0 and c_out=1.
REQ-030 Scenario: a=255, b=1111, c_in=0 -> sum=1366 and c_out=0.
REQ-031 Scenario: a=65535, b=0, c_in=1 -> sum=0 and c_out=1, exercising full ripple across the slices.
REQ-032 Scenario: random a/b/c_in every cycle for at least 10000 cycles -> outputs at cycle N+1 match the reference model a+b+c_in from cycle N; include a reset pulse mid-stream and check that outputs clear asynchronously.

Source files
------------

// File: rtl/cla_16_bit_ripple.sv
// Registered 16-bit adder: {c_out, sum} = a + b + c_in, built from four 4-bit carry-lookahead slices with ripple between slices.
// Ports: clk, rst_n (async active-low), a/b [15:0] operands, c_in carry-in; sum [15:0], c_out registered result.
// Latency 1 cycle; no enable or backpressure, a new result is captured on every rising clk edge.
module cla_16_bit_ripple (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] sum_d;
  logic [15:0] sum_q;
  logic        c_out_d;
  logic        c_out_q;

  // Per-slice working values, rewritten for each slice in the loop below.
  logic [3:0]  slice_g;
  logic [3:0]  slice_p;
  logic [4:0]  slice_c;   // slice_c[0] is the slice carry-in, slice_c[4] its carry-out
  logic        ripple_c;  // carry handed from one slice to the next

  // Each slice computes all four carries directly from g, p and its carry-in
  // (two-level sum of products); only the slice carry-out ripples onward.
  always_comb begin
    sum_d    = '0;
    slice_g  = '0;
    slice_p  = '0;
    slice_c  = '0;
    ripple_c = c_in;
    for (int k = 0; k < 4; k++) begin
      slice_g    = a[4*k +: 4] & b[4*k +: 4];
      slice_p    = a[4*k +: 4] ^ b[4*k +: 4];
      slice_c[0] = ripple_c;
      slice_c[1] = slice_g[0]
                 | (slice_p[0] & slice_c[0]);
      slice_c[2] = slice_g[1]
                 | (slice_p[1] & slice_g[0])
                 | (slice_p[1] & slice_p[0] & slice_c[0]);
      slice_c[3] = slice_g[2]
                 | (slice_p[2] & slice_g[1])
                 | (slice_p[2] & slice_p[1] & slice_g[0])
                 | (slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
      slice_c[4] = slice_g[3]
                 | (slice_p[3] & slice_g[2])
                 | (slice_p[3] & slice_p[2] & slice_g[1])
                 | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
                 | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
      sum_d[4*k +: 4] = slice_p ^ slice_c[3:0];
      ripple_c        = slice_c[4];
    end
    c_out_d = ripple_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_cla_16_bit_ripple.sv
// Self-checking bench for cla_16_bit_ripple: directed vectors plus a long random run against a+b+c_in.
// Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
// Includes async reset checks at start and mid-stream.
module tb_cla_16_bit_ripple;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic [15:0] sum;
  logic        c_out;

  int checks;
  int errors;

  cla_16_bit_ripple dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got {c_out,sum}=%05h expected %05h", tag, obs, exp);
    end
  endtask

  // Drive one vector, let one rising edge capture it, compare against the given result.
  task automatic apply(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic vc, input logic [16:0] exp);
    @(negedge clk);
    a    = va;
    b    = vb;
    c_in = vc;
    @(posedge clk);
    #1;
    chk(tag, {c_out, sum}, exp);
  endtask

  logic [15:0] ra;
  logic [15:0] rb;
  logic        rc;
  logic [16:0] model;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a      = 16'hA5A5;
    b      = 16'h7F3C;
    c_in   = 1'b1;

    // Reset held with live inputs and a running clock.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", {c_out, sum}, 17'h0_0000);

    // First edge after release loads the live inputs: 1 + 2 + 0 = 3.
    @(negedge clk);
    rst_n = 1'b1;
    a     = 16'd1;
    b     = 16'd2;
    c_in  = 1'b0;
    @(posedge clk);
    #1;
    chk("first_after_reset", {c_out, sum}, 17'd3);

    // Directed vectors with hand-computed results.
    apply("add_12345_32914", 16'd12345, 16'd32914, 1'b0, {1'b0, 16'd45259});
    // Result holds until the next rising edge.
    @(negedge clk);
    #1;
    chk("hold_to_next_edge", {c_out, sum}, {1'b0, 16'd45259});
    apply("msb_carry",       16'h8000, 16'h8000, 1'b0, {1'b1, 16'h0000});
    apply("add_255_1111",    16'd255,  16'd1111, 1'b0, {1'b0, 16'd1366});
    apply("full_ripple",     16'hFFFF, 16'h0000, 1'b1, {1'b1, 16'h0000});
    apply("all_ones_cin",    16'hFFFF, 16'hFFFF, 1'b1, {1'b1, 16'hFFFF});
    apply("zero",            16'h0000, 16'h0000, 1'b0, {1'b0, 16'h0000});
    apply("cin_only",        16'h0000, 16'h0000, 1'b1, {1'b0, 16'h0001});
    apply("slice_boundary",  16'h000F, 16'h0001, 1'b0, {1'b0, 16'h0010});
    apply("slice_chain",     16'h0FFF, 16'h0000, 1'b1, {1'b0, 16'h1000});
    apply("alt_bits",        16'hAAAA, 16'h5555, 1'b0, {1'b0, 16'hFFFF});
    apply("alt_bits_cin",    16'hAAAA, 16'h5555, 1'b1, {1'b1, 16'h0000});
    apply("mid_carry",       16'h1234, 16'hEDCC, 1'b0, {1'b1, 16'h0000});
    // Same vector again after different traffic: no history.
    apply("add_255_1111_rep", 16'd255, 16'd1111, 1'b0, {1'b0, 16'd1366});

    // Random run against a behavioural model, with a reset pulse mid-stream.
    for (int i = 0; i < 10000; i++) begin
      ra    = 16'($urandom);
      rb    = 16'($urandom);
      rc    = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      apply("random", ra, rb, rc, model);
      if (i == 5000) begin
        // Assert reset away from any clock edge; outputs must clear at once.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_clear", {c_out, sum}, 17'h0_0000);
        @(posedge clk);
        #1;
        chk("reset_mid_hold", {c_out, sum}, 17'h0_0000);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
